uart_tx_fifo: RTL and testbench

Parametrised buffered UART transmitter for the GoBoard UART designs. It accepts bytes on a write strobe, typically o_RX_DV/o_RX_Byte from UART_RX, and queues them in an internal FIFO of DEPTH entries. It serialises the queued bytes back-to-back with configurable data width, parity and stop bits. Dropped bytes are flagged by a sticky overflow, and o_Last_Byte is exported for DisplayNumber.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_byte_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, TX state encoding and frame-length helper for the buffered UART transmitter.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int unsigned frame_cycles(input int unsigned cpb, input int unsigned data_bits,
                                                 input int unsigned parity, input int unsigned stop_bits);
        int unsigned par_bits;
        par_bits = (parity != PARITY_NONE) ? 32'd1 : 32'd0;
        return (32'd1 + data_bits + par_bits + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous DEPTH x DATA_BITS FIFO with registered count/empty/full flags.
module uart_byte_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic [DATA_BITS-1:0] rd_data_c,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 drop_c
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic                 push_c;
    logic                 pop_c;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop_c     = rd_en && !empty;
    assign push_c    = wr_en && (!full || pop_c);
    assign drop_c    = wr_en && full && !pop_c;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_c && !pop_c) begin
            count_next = count + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == CNT_W'(0));
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queues written bytes and serialises them back-to-back
// with configurable data width, parity and stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned DEPTH        = 4,
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_Wr_DV,
    input  logic [DATA_BITS-1:0] i_Wr_Byte,
    input  logic                 i_Clr_Ovf,
    output logic [CNT_W-1:0]     o_Count,
    output logic                 o_Empty,
    output logic                 o_Full,
    output logic                 o_Overflow,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Active,
    output logic                 o_TX_Done,
    output logic [DATA_BITS-1:0] o_Last_Byte
);

    localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    tx_state_e            state, state_next;
    logic [CLK_W-1:0]     clk_cnt, clk_cnt_next;
    logic [BIT_W-1:0]     bit_idx, bit_idx_next;
    logic                 stop_idx, stop_idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 parity_bit, parity_bit_next;
    logic                 serial_next;
    logic                 active_next;
    logic                 done_next;
    logic [DATA_BITS-1:0] last_next;
    logic [DATA_BITS-1:0] head_c;
    logic                 pop_c;
    logic                 drop_c;
    logic                 bit_end_c;

    uart_byte_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (i_Clock),
        .rst_n     (i_Rst_L),
        .wr_en     (i_Wr_DV),
        .rd_en     (pop_c),
        .wr_data   (i_Wr_Byte),
        .rd_data_c (head_c),
        .count     (o_Count),
        .empty     (o_Empty),
        .full      (o_Full),
        .drop_c    (drop_c)
    );

    assign bit_end_c = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Overflow <= 1'b0;
        end else if (drop_c) begin
            o_Overflow <= 1'b1;
        end else if (i_Clr_Ovf) begin
            o_Overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= TX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
            o_Last_Byte <= '0;
        end else begin
            state       <= state_next;
            clk_cnt     <= clk_cnt_next;
            bit_idx     <= bit_idx_next;
            stop_idx    <= stop_idx_next;
            shreg       <= shreg_next;
            parity_bit  <= parity_bit_next;
            o_TX_Serial <= serial_next;
            o_TX_Active <= active_next;
            o_TX_Done   <= done_next;
            o_Last_Byte <= last_next;
        end
    end

    // Line value is computed for the state being entered so the serial output stays registered.
    always_comb begin
        state_next      = state;
        clk_cnt_next    = clk_cnt;
        bit_idx_next    = bit_idx;
        stop_idx_next   = stop_idx;
        shreg_next      = shreg;
        parity_bit_next = parity_bit;
        serial_next     = o_TX_Serial;
        done_next       = 1'b0;
        last_next       = o_Last_Byte;
        pop_c           = 1'b0;

        if (state != TX_IDLE) begin
            clk_cnt_next = bit_end_c ? '0 : clk_cnt + CLK_W'(1);
        end

        case (state)
            TX_IDLE: begin
                serial_next = 1'b1;
                if (!o_Empty) begin
                    pop_c           = 1'b1;
                    last_next       = head_c;
                    shreg_next      = head_c;
                    parity_bit_next = (PARITY == PARITY_ODD) ? ~^head_c : ^head_c;
                    clk_cnt_next    = '0;
                    state_next      = TX_START;
                    serial_next     = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end_c) begin
                    bit_idx_next = '0;
                    state_next   = TX_DATA;
                    serial_next  = shreg[0];
                end
            end
            TX_DATA: begin
                if (bit_end_c) begin
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        if (PARITY != PARITY_NONE) begin
                            state_next  = TX_PARITY;
                            serial_next = parity_bit;
                        end else begin
                            state_next    = TX_STOP;
                            stop_idx_next = 1'b0;
                            serial_next   = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + BIT_W'(1);
                        shreg_next   = shreg >> 1;
                        serial_next  = shreg[1];
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end_c) begin
                    state_next    = TX_STOP;
                    stop_idx_next = 1'b0;
                    serial_next   = 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end_c) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        state_next  = TX_IDLE;
                        done_next   = 1'b1;
                        serial_next = 1'b1;
                    end else begin
                        stop_idx_next = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next  = TX_IDLE;
                serial_next = 1'b1;
            end
        endcase

        active_next = (state_next != TX_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover plain, even/odd parity and two-stop-bit framing.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr   [4];
    logic [7:0] wb   [4];
    logic [2:0] cnt  [4];
    logic       emp  [4];
    logic       ful  [4];
    logic       ovf  [4];
    logic       ser  [4];
    logic       act  [4];
    logic       dn   [4];
    logic [7:0] last [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: plain 8N1, 1: even parity, 2: odd parity, 3: two stop bits
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u0 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr[0]), .i_Wr_Byte(wb[0]), .i_Clr_Ovf(clr),
        .o_Count(cnt[0]), .o_Empty(emp[0]), .o_Full(ful[0]), .o_Overflow(ovf[0]),
        .o_TX_Serial(ser[0]), .o_TX_Active(act[0]), .o_TX_Done(dn[0]), .o_Last_Byte(last[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr[1]), .i_Wr_Byte(wb[1]), .i_Clr_Ovf(clr),
        .o_Count(cnt[1]), .o_Empty(emp[1]), .o_Full(ful[1]), .o_Overflow(ovf[1]),
        .o_TX_Serial(ser[1]), .o_TX_Active(act[1]), .o_TX_Done(dn[1]), .o_Last_Byte(last[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u2 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr[2]), .i_Wr_Byte(wb[2]), .i_Clr_Ovf(clr),
        .o_Count(cnt[2]), .o_Empty(emp[2]), .o_Full(ful[2]), .o_Overflow(ovf[2]),
        .o_TX_Serial(ser[2]), .o_TX_Active(act[2]), .o_TX_Done(dn[2]), .o_Last_Byte(last[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) u3 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr[3]), .i_Wr_Byte(wb[3]), .i_Clr_Ovf(clr),
        .o_Count(cnt[3]), .o_Empty(emp[3]), .o_Full(ful[3]), .o_Overflow(ovf[3]),
        .o_TX_Serial(ser[3]), .o_TX_Active(act[3]), .o_TX_Done(dn[3]), .o_Last_Byte(last[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 1'b0;
            wb[i] = 8'h00;
        end
        #12;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ser[i], act[i], dn[i], emp[i], ful[i], ovf[i]} !== 6'b100100 || cnt[i] !== 3'd0 || last[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_state u%0d: got ser=%b act=%b dn=%b emp=%b ful=%b ovf=%b cnt=%0d last=%h, need 1 0 0 1 0 0 0 00",
                         i, ser[i], act[i], dn[i], emp[i], ful[i], ovf[i], cnt[i], last[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ser[i] !== 1'b1 || act[i] !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle u%0d: got ser=%b act=%b, need 1 0", i, ser[i], act[i]);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [15:0] fr;
        fr = 16'b000000_1_01100011_0;
        wr[0] = 1'b1;
        wb[0] = 8'h63;
        tick();
        wr[0] = 1'b0;
        tick();
        checks++;
        if (last[0] !== 8'h63 || act[0] !== 1'b1 || cnt[0] !== 3'd0) begin
            failures++;
            $display("FAIL t1_pop: got last=%h act=%b cnt=%0d, need 63 1 0", last[0], act[0], cnt[0]);
        end
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (ser[0] !== fr[k / CPB] || dn[0] !== 1'b0) begin
                failures++;
                $display("FAIL t1_frame cycle=%0d: got ser=%b dn=%b, need ser=%b dn=0", k, ser[0], dn[0], fr[k / CPB]);
            end
            tick();
        end
        checks++;
        if (dn[0] !== 1'b1 || act[0] !== 1'b0 || ser[0] !== 1'b1) begin
            failures++;
            $display("FAIL t1_done: got dn=%b act=%b ser=%b, need 1 0 1", dn[0], act[0], ser[0]);
        end
        tick();
        checks++;
        if (dn[0] !== 1'b0 || ser[0] !== 1'b1) begin
            failures++;
            $display("FAIL t1_done_width: got dn=%b ser=%b, need 0 1", dn[0], ser[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b;
        logic [15:0] fr;
        int          f;
        int          pos;
        for (int j = 0; j < 6; j++) begin
            wr[0] = 1'b1;
            wb[0] = 8'hA0 + 8'(j);
            tick();
        end
        wr[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b1 || cnt[0] !== 3'd4 || ful[0] !== 1'b1) begin
            failures++;
            $display("FAIL t2_overflow: got ovf=%b cnt=%0d full=%b, need 1 4 1", ovf[0], cnt[0], ful[0]);
        end
        // t counts cycles from the A0 pop edge; each frame plus its idle gap spans 41 cycles
        for (int t = 4; t < 205; t++) begin
            f   = t / 41;
            pos = t % 41;
            b   = 8'hA0 + 8'(f);
            fr  = {6'b0, 1'b1, b, 1'b0};
            checks++;
            if (pos < 40) begin
                if (ser[0] !== fr[pos / CPB] || dn[0] !== 1'b0 || act[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL t2_frame f=%0d pos=%0d: got ser=%b dn=%b act=%b, need ser=%b dn=0 act=1",
                             f, pos, ser[0], dn[0], act[0], fr[pos / CPB]);
                end
            end else begin
                if (ser[0] !== 1'b1 || dn[0] !== 1'b1 || act[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL t2_gap f=%0d: got ser=%b dn=%b act=%b, need 1 1 0", f, ser[0], dn[0], act[0]);
                end
            end
            if (pos == 0) begin
                checks++;
                if (last[0] !== b) begin
                    failures++;
                    $display("FAIL t2_last f=%0d: got %h, need %h", f, last[0], b);
                end
            end
            tick();
        end
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (ser[0] !== 1'b1 || act[0] !== 1'b0 || emp[0] !== 1'b1) begin
                failures++;
                $display("FAIL t2_drained cycle=%0d: got ser=%b act=%b emp=%b, need 1 0 1", k, ser[0], act[0], emp[0]);
            end
            tick();
        end
    endtask

    task automatic test_parity();
        logic [15:0] fr_even;
        logic [15:0] fr_odd;
        fr_even = 16'b00000_1_1_00000111_0;
        fr_odd  = 16'b00000_1_0_00000111_0;
        wr[1] = 1'b1; wb[1] = 8'h07;
        wr[2] = 1'b1; wb[2] = 8'h07;
        tick();
        wr[1] = 1'b0;
        wr[2] = 1'b0;
        tick();
        for (int k = 0; k < 44; k++) begin
            checks++;
            if (ser[1] !== fr_even[k / CPB] || dn[1] !== 1'b0) begin
                failures++;
                $display("FAIL t3_even cycle=%0d: got ser=%b dn=%b, need ser=%b dn=0", k, ser[1], dn[1], fr_even[k / CPB]);
            end
            checks++;
            if (ser[2] !== fr_odd[k / CPB] || dn[2] !== 1'b0) begin
                failures++;
                $display("FAIL t3_odd cycle=%0d: got ser=%b dn=%b, need ser=%b dn=0", k, ser[2], dn[2], fr_odd[k / CPB]);
            end
            tick();
        end
        checks++;
        if (dn[1] !== 1'b1 || dn[2] !== 1'b1 || act[1] !== 1'b0 || act[2] !== 1'b0) begin
            failures++;
            $display("FAIL t3_done: got dn=%b%b act=%b%b, need dn=11 act=00", dn[1], dn[2], act[1], act[2]);
        end
    endtask

    task automatic test_two_stop();
        logic [15:0] fr;
        fr = 16'b00000_11_11111111_0;
        wr[3] = 1'b1;
        wb[3] = 8'hFF;
        tick();
        wr[3] = 1'b0;
        tick();
        for (int k = 0; k < 44; k++) begin
            checks++;
            if (ser[3] !== fr[k / CPB] || dn[3] !== 1'b0 || act[3] !== 1'b1) begin
                failures++;
                $display("FAIL t4_frame cycle=%0d: got ser=%b dn=%b act=%b, need ser=%b dn=0 act=1",
                         k, ser[3], dn[3], act[3], fr[k / CPB]);
            end
            tick();
        end
        checks++;
        if (dn[3] !== 1'b1 || act[3] !== 1'b0 || ser[3] !== 1'b1) begin
            failures++;
            $display("FAIL t4_done: got dn=%b act=%b ser=%b, need 1 0 1", dn[3], act[3], ser[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int j = 0; j < 3; j++) begin
            wr[0] = 1'b1;
            wb[0] = 8'h00;
            tick();
        end
        wr[0] = 1'b0;
        // now one cycle past the pop edge; advance into data bit 3 (cycles 16..19)
        for (int k = 0; k < 16; k++) tick();
        checks++;
        if (ser[0] !== 1'b0 || cnt[0] !== 3'd2 || act[0] !== 1'b1) begin
            failures++;
            $display("FAIL t5_mid_frame: got ser=%b cnt=%0d act=%b, need 0 2 1", ser[0], cnt[0], act[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ser[0] !== 1'b1 || cnt[0] !== 3'd0 || act[0] !== 1'b0 || emp[0] !== 1'b1 || ovf[0] !== 1'b0 || last[0] !== 8'h00) begin
            failures++;
            $display("FAIL t5_async_reset: got ser=%b cnt=%0d act=%b emp=%b ovf=%b last=%h, need 1 0 0 1 0 00",
                     ser[0], cnt[0], act[0], emp[0], ovf[0], last[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            checks++;
            if (ser[0] !== 1'b1 || act[0] !== 1'b0) begin
                failures++;
                $display("FAIL t5_no_residual cycle=%0d: got ser=%b act=%b, need 1 0", k, ser[0], act[0]);
            end
        end
    endtask

    task automatic test_overflow_clear();
        for (int j = 0; j < 5; j++) begin
            wr[0] = 1'b1;
            wb[0] = 8'hB0 + 8'(j);
            tick();
        end
        checks++;
        if (ful[0] !== 1'b1 || cnt[0] !== 3'd4 || ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL t6_full: got full=%b cnt=%0d ovf=%b, need 1 4 0", ful[0], cnt[0], ovf[0]);
        end
        wb[0] = 8'hB5;
        clr   = 1'b1;
        tick();
        wr[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b1 || cnt[0] !== 3'd4) begin
            failures++;
            $display("FAIL t6_set_wins: got ovf=%b cnt=%0d, need 1 4", ovf[0], cnt[0]);
        end
        tick();
        clr = 1'b0;
        checks++;
        if (ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL t6_clear: got ovf=%b, need 0", ovf[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_reset_mid_frame();
        test_overflow_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
